// File: rtl/dot_acc_pkg.sv
// ============================================================================
// Module   : dot_acc_pkg
// Brief    : Shared FSM encodings and default sizes for dot_product_acc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dot_acc_pkg;

    localparam int C_OP_W      = 8;
    localparam int C_DEF_LEN   = 4;
    localparam int C_DEF_ACC_W = 10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_signed.sv
// ============================================================================
// Module   : mul_signed
// Brief    : Signed multiply truncated to operand width, with overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_signed #(
    parameter int OP_W = 8
) (
    input  logic signed [OP_W-1:0] a,
    input  logic signed [OP_W-1:0] b,
    output logic        [OP_W-1:0] prod,
    output logic                   ovf
);

    logic signed [2*OP_W-1:0] w_full;

    assign w_full = a * b;
    assign prod   = w_full[OP_W-1:0];
    // Overflow when the upper half is not a pure sign extension of the low half.
    assign ovf    = (w_full[2*OP_W-1:OP_W] != {OP_W{w_full[OP_W-1]}});

endmodule

`default_nettype wire

// File: rtl/dot_product_acc.sv
// ============================================================================
// Module   : dot_product_acc
// Brief    : Streaming signed dot-product accumulator over LEN operand pairs.
//            Define DOT_ACC_SAT_EN to saturate the accumulator instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_acc
    import dot_acc_pkg::*;
#(
    parameter int LEN   = C_DEF_LEN,
    parameter int ACC_W = C_DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [C_OP_W-1:0] a,
    input  logic signed [C_OP_W-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [ACC_W-1:0]  out_sum,
    output logic                     out_ovf
);

    localparam logic [7:0] C_LAST = 8'(LEN - 1);

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic [C_OP_W-1:0]   r_p_reg;
    logic                r_p_ovf;
    logic                r_p_vld;
    logic [ACC_W-1:0]    r_acc;
    logic                r_sticky;

    logic [C_OP_W-1:0]   w_prod;
    logic                w_prod_ovf;
    logic                w_hs;
    logic [ACC_W:0]      w_sum_x;
    logic                w_acc_ovf;
    logic [ACC_W-1:0]    w_acc_nxt;

    mul_signed #(
        .OP_W (C_OP_W)
    ) u_mul (
        .a    (a),
        .b    (b),
        .prod (w_prod),
        .ovf  (w_prod_ovf)
    );

    assign in_ready  = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_acc;
    assign out_ovf   = r_sticky;
    assign w_hs      = in_valid && (r_state == RUN);

    // One guard bit: overflow shows up as disagreement between the top two bits.
    assign w_sum_x   = {r_acc[ACC_W-1], r_acc}
                     + {{(ACC_W+1-C_OP_W){r_p_reg[C_OP_W-1]}}, r_p_reg};
    assign w_acc_ovf = w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1];

    always_comb begin
        w_acc_nxt = w_sum_x[ACC_W-1:0];
`ifdef DOT_ACC_SAT_EN
        if (w_acc_ovf) begin
            w_acc_nxt = w_sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_cnt    <= 8'd0;
            r_p_reg  <= '0;
            r_p_ovf  <= 1'b0;
            r_p_vld  <= 1'b0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_p_vld <= w_hs;
            if (w_hs) begin
                r_p_reg <= w_prod;
                r_p_ovf <= w_prod_ovf;
            end
            if (r_p_vld) begin
                r_acc    <= w_acc_nxt;
                r_sticky <= r_sticky | r_p_ovf | w_acc_ovf;
            end
            case (r_state)
                RUN: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == C_LAST) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // p_vld low means the last product has already landed in acc.
                    if (!r_p_vld) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state  <= RUN;
                        r_cnt    <= 8'd0;
                        r_acc    <= '0;
                        r_sticky <= 1'b0;
                        r_p_vld  <= 1'b0;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dot_product_acc.sv
// ============================================================================
// Module   : tb_dot_product_acc
// Brief    : Self-checking bench: LEN=4 and LEN=8 instances vs arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_product_acc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_valid_v = 2'b00;
    logic [1:0] in_ready_v;
    logic [1:0] out_valid_v;
    logic [1:0] out_ready_v = 2'b00;
    logic [1:0] out_ovf_v;
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];
    logic [9:0] sum_v [2];

    int n_cmp = 0;
    int n_err = 0;
    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    dot_product_acc #(.LEN(4), .ACC_W(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_sum(sum_v[0]), .out_ovf(out_ovf_v[0])
    );

    dot_product_acc #(.LEN(8), .ACC_W(10)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_sum(sum_v[1]), .out_ovf(out_ovf_v[1])
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dot product straight from the arithmetic rules, 10-bit accumulator.
    task automatic ref_model(output int s, output bit o);
        int p;
        s = 0;
        o = 1'b0;
        foreach (qa[i]) begin
            p = qa[i] * qb[i];
            if (p > 127 || p < -128) o = 1'b1;
            p = ((p % 256) + 256) % 256;
            if (p >= 128) p -= 256;
            s += p;
            if (s > 511 || s < -512) begin
                o = 1'b1;
`ifdef DOT_ACC_SAT_EN
                s = (s > 511) ? 511 : -512;
`else
                s = ((s % 1024) + 1024) % 1024;
                if (s >= 512) s -= 1024;
`endif
            end
        end
    endtask

    task automatic set_pairs(input int n, input int a0, input int b0, input int a1,
                             input int b1, input int a2, input int b2,
                             input int a3, input int b3);
        int av[4];
        int bv[4];
        av = '{a0, a1, a2, a3};
        bv = '{b0, b1, b2, b3};
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(av[i % 4]);
            qb.push_back(bv[i % 4]);
        end
    endtask

    task automatic rand_pairs(input int n);
        logic [7:0] t;
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            t = 8'($urandom);
            qa.push_back(int'($signed(t)));
            t = 8'($urandom);
            qb.push_back(int'($signed(t)));
        end
    endtask

    // Feed qa/qb into one instance, check latency/result, then consume.
    task automatic do_run(input int sel, input int gap, input bit rnd_gap,
                          input int hold);
        int es;
        bit eo;
        int k;
        int g;
        logic [9:0] held;
        ref_model(es, eo);
        for (int i = 0; i < qa.size(); i++) begin
            chk("in_ready_run", in_ready_v[sel], 1);
            in_valid_v[sel] = 1'b1;
            a_v[sel] = 8'(qa[i]);
            b_v[sel] = 8'(qb[i]);
            tick();
            in_valid_v[sel] = 1'b0;
            a_v[sel] = 8'($urandom);
            b_v[sel] = 8'($urandom);
            if (i != qa.size() - 1) begin
                g = rnd_gap ? int'($urandom_range(0, 3)) : gap;
                repeat (g) tick();
            end
        end
        k = 0;
        while (out_valid_v[sel] !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("out_valid_latency", k, 2);
        chk("out_sum", $signed(sum_v[sel]), es);
        chk("out_ovf", out_ovf_v[sel], 32'(eo));
        held = sum_v[sel];
        for (int i = 0; i < hold; i++) begin
            in_valid_v[sel] = 1'($urandom);
            a_v[sel] = 8'($urandom);
            b_v[sel] = 8'($urandom);
            tick();
            chk("hold_sum", $signed(sum_v[sel]), $signed(held));
            chk("hold_in_ready", in_ready_v[sel], 0);
            chk("hold_out_valid", out_valid_v[sel], 1);
        end
        // Offer a pair during the consume edge; it must not be taken.
        in_valid_v[sel] = (hold > 0);
        a_v[sel] = 8'd100;
        b_v[sel] = 8'd3;
        out_ready_v[sel] = 1'b1;
        tick();
        out_ready_v[sel] = 1'b0;
        in_valid_v[sel] = 1'b0;
        chk("post_in_ready", in_ready_v[sel], 1);
        chk("post_out_valid", out_valid_v[sel], 0);
        tick();
        tick();
        chk("post_sum_clear", $signed(sum_v[sel]), 0);
        chk("post_ovf_clear", out_ovf_v[sel], 0);
    endtask

    initial begin
        a_v[0] = '0; b_v[0] = '0; a_v[1] = '0; b_v[1] = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", in_ready_v[s], 1);
            chk("rst_out_valid", out_valid_v[s], 0);
            chk("rst_sum", $signed(sum_v[s]), 0);
            chk("rst_ovf", out_ovf_v[s], 0);
        end

        // Back-to-back reference vector: 2 + 35 + 88 - 30 = 95.
        set_pairs(4, 1, 2, 7, 5, 11, 8, -2, 15);
        do_run(0, 0, 1'b0, 0);

        // Product 12*14 wraps to -88.
        set_pairs(4, 12, 14, 1, 1, 1, 1, 1, 1);
        do_run(0, 0, 1'b0, 0);

        // Accumulator overflow on the LEN=8 instance.
        set_pairs(8, 127, 1, 127, 1, 127, 1, 127, 1);
        do_run(1, 0, 1'b0, 0);

        // Stall in DONE for 5 cycles with toggling inputs.
        set_pairs(4, 1, 2, 7, 5, 11, 8, -2, 15);
        do_run(0, 0, 1'b0, 5);

        // Three-cycle bubbles between pairs.
        do_run(0, 3, 1'b0, 0);

        // Abort mid-run with reset; a handshake coincides with the reset edge.
        set_pairs(2, 50, 3, 60, 2, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            in_valid_v[0] = 1'b1;
            a_v[0] = 8'(qa[i]);
            b_v[0] = 8'(qb[i]);
            tick();
        end
        rst_n = 1'b0;
        a_v[0] = 8'd9;
        b_v[0] = 8'd9;
        tick();
        rst_n = 1'b1;
        in_valid_v[0] = 1'b0;
        chk("abort_in_ready", in_ready_v[0], 1);
        chk("abort_out_valid", out_valid_v[0], 0);
        chk("abort_sum", $signed(sum_v[0]), 0);
        tick();
        chk("abort_sum_later", $signed(sum_v[0]), 0);
        set_pairs(4, 1, 2, 7, 5, 11, 8, -2, 15);
        do_run(0, 0, 1'b0, 0);

        // Random operands with random bubbles on both instances.
        for (int r = 0; r < 6; r++) begin
            rand_pairs(4);
            do_run(0, 0, 1'b1, int'($urandom_range(0, 2)));
            rand_pairs(8);
            do_run(1, 0, 1'b1, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dot_product_acc.md
DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

Interface
REQ-001 SHALL have parameter LEN, default 4; number of operand pairs per dot product, legal range 1..255.
REQ-002 SHALL have parameter ACC_W, default 10; accumulator and result width in bits, legal range 9..24.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit; an operand pair is present.
REQ-006 SHALL have port in_ready, output, 1 bit; the block accepts a pair this cycle.
REQ-007 SHALL have port a, input, 8 bits; signed two's-complement multiplicand.
REQ-008 SHALL have port b, input, 8 bits; signed two's-complement multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit; the result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit; the consumer takes the result.
REQ-011 SHALL have port out_sum, output, ACC_W bits; signed dot-product result.
REQ-012 SHALL have port out_ovf, output, 1 bit; sticky flag, set when any product overflowed or the accumulator overflowed.

Function
REQ-013 An input handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; in every other cycle a and b SHALL be ignored.
REQ-014 On each handshake, the signed 8-bit product (low 8 bits) and its overflow flag from mul_signed SHALL be registered into p_reg and p_vld.
REQ-015 On the edge after p_vld=1, acc SHALL be updated to acc + sign-extend(p_reg), and the sticky flag SHALL be ORed with the registered product overflow.
REQ-016 The FSM SHALL have exactly three states: RUN (in_ready=1), DRAIN (in_ready=0), and DONE (in_ready=0, out_valid=1).
REQ-017 RUN SHALL count handshakes; on the LEN-th handshake it SHALL transition to DRAIN.
REQ-018 DRAIN SHALL transition to DONE once the final product has been accumulated, so out_valid first rises 2 cycles after the LEN-th handshake edge.
REQ-019 In DONE, out_sum and out_ovf SHALL be held stable until out_ready=1.
REQ-020 When out_ready=1 in DONE, acc, the count, the sticky flag and p_vld SHALL be cleared, and the FSM SHALL enter RUN on that edge.
REQ-021 No input SHALL be accepted in the same cycle as output consumption.
REQ-022 Cycles with in_valid=0 in RUN SHALL leave acc and the count unchanged; bubbles SHALL NOT affect the result.
REQ-023 out_sum SHALL equal acc; out_ovf SHALL equal the sticky flag.
REQ-024 Whenever out_valid=0, out_sum and out_ovf SHALL be don't-care to consumers.

Reset
REQ-025 When rst_n=0 at a rising edge, the following SHALL hold at the next cycle, including mid-operation: state=RUN, count=0, acc=0, sticky=0, p_vld=0, out_valid=0, out_sum=0, out_ovf=0, in_ready=1.
REQ-026 A handshake coinciding with reset SHALL be discarded.

Configuration
REQ-027 With macro DOT_ACC_SAT_EN defined, an accumulate exceeding the signed ACC_W range SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and set the sticky flag.
REQ-028 Without DOT_ACC_SAT_EN, an accumulate exceeding the signed ACC_W range SHALL wrap modulo 2^ACC_W and set the sticky flag.

Structure
REQ-029 The shared package dot_acc_pkg SHALL hold: the state encodings (RUN=2'd0, DRAIN=2'd1, DONE=2'd2), the default LEN and ACC_W, and the operand width constant (8).
REQ-030 dot_product_acc SHALL instantiate exactly one existing mul_signed sub-module for the product and overflow; all other logic SHALL be local.
REQ-031 There SHALL be no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Verification
REQ-032 With LEN=4, pairs (1,2),(7,5),(11,8),(-2,15) back-to-back -> out_sum=95, out_ovf=0, out_valid rises 2 cycles after the 4th handshake.
REQ-033 With LEN=4, pairs (12,14),(1,1),(1,1),(1,1) -> the product wraps to -88, out_sum=-85, out_ovf=1.
REQ-034 With LEN=8, ACC_W=10, eight pairs (127,1) -> with DOT_ACC_SAT_EN: out_sum=511, out_ovf=1; without it: out_sum=-8, out_ovf=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid -> out_sum is stable, in_ready=0, no handshake occurs; on the following out_ready=1 the FSM enters RUN with acc=0.
REQ-036 Pulse rst_n=0 for 1 cycle after 2 handshakes, then send the REQ-032 pairs -> out_sum=95 with no residue from the aborted run.
REQ-037 Send the REQ-032 pairs with in_valid=0 for 3 cycles between each pair -> out_sum=95, out_ovf=0.
